// File: rtl/return_address_stack_if.sv
// Fetch-side and EX-side signals of the return address stack.
// Master drives fetch/recover inputs; slave is the RAS itself.
interface return_address_stack_if #(
   parameter int XLEN  = 32,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
);
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  instruction;
   logic             fetch_en;
   logic             ras_valid;
   logic [XLEN-1:0]  ras_target;
   logic [PTR_W-1:0] ckpt_tos;
   logic [CNT_W-1:0] ckpt_count;
   logic [XLEN-1:0]  ckpt_top;
   logic             recover_en;
   logic [PTR_W-1:0] recover_tos;
   logic [CNT_W-1:0] recover_count;
   logic [XLEN-1:0]  recover_top;

   modport master (
      output pc, instruction, fetch_en,
      output recover_en, recover_tos,
      output recover_count, recover_top,
      input  ras_valid, ras_target,
      input  ckpt_tos, ckpt_count, ckpt_top
   );

   modport slave (
      input  pc, instruction, fetch_en,
      input  recover_en, recover_tos,
      input  recover_count, recover_top,
      output ras_valid, ras_target,
      output ckpt_tos, ckpt_count, ckpt_top
   );
endinterface

// File: rtl/return_address_stack.sv
// Speculative return address stack for IF with checkpoint recovery.
// Ports: clk, reset (sync, active-high), ras = slave side of the RAS bus.
module return_address_stack #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH) + 1,
   parameter int XLEN  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   return_address_stack_if.slave ras
);

   typedef enum logic [6:0] {
      OP_JAL  = 7'b1101111,
      OP_JALR = 7'b1100111
   } opcode_e;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_PUSH,
      ACT_POP,
      ACT_POPPUSH
   } action_e;

   logic [XLEN-1:0]  stack [DEPTH];
   logic [PTR_W-1:0] tos;
   logic [CNT_W-1:0] count;

   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic             rd_link;
   logic             rs1_link;
   logic             is_jal;
   logic             is_jalr;
   action_e          action;

   logic [PTR_W-1:0] tos_inc;
   logic [PTR_W-1:0] tos_dec;
   logic [XLEN-1:0]  ret_addr;

   function automatic logic link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   assign rd       = ras.instruction[11:7];
   assign rs1      = ras.instruction[19:15];
   assign rd_link  = link(rd);
   assign rs1_link = link(rs1);
   assign is_jal   = ras.instruction[6:0] == OP_JAL;
   assign is_jalr  = ras.instruction[6:0] == OP_JALR;

   always_comb begin
      action = ACT_NONE;
      unique case (1'b1)
         is_jal: begin
            if (rd_link)
               action = ACT_PUSH;
         end
         is_jalr: begin
            if (rd_link && rs1_link && rd != rs1)
               action = ACT_POPPUSH;
            else if (rd_link)
               action = ACT_PUSH;
            else if (rs1_link)
               action = ACT_POP;
         end
         default: action = ACT_NONE;
      endcase
   end

   // Pointer math wraps naturally at PTR_W bits (DEPTH is 2**PTR_W).
   assign tos_inc  = tos + PTR_W'(1);
   assign tos_dec  = tos - PTR_W'(1);
   assign ret_addr = ras.pc + XLEN'(4);

   always_ff @(posedge clk) begin
      if (reset) begin
         tos   <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++)
            stack[i] <= '0;
      end else if (ras.recover_en) begin
         // Only the top entry is repaired; deeper corruption is tolerated.
         tos                     <= ras.recover_tos;
         count                   <= ras.recover_count;
         stack[ras.recover_tos]  <= ras.recover_top;
      end else if (ras.fetch_en) begin
         unique case (action)
            ACT_PUSH: begin
               tos            <= tos_inc;
               stack[tos_inc] <= ret_addr;
               if (count != CNT_W'(DEPTH))
                  count <= count + CNT_W'(1);
            end
            ACT_POP: begin
               if (count != '0) begin
                  tos   <= tos_dec;
                  count <= count - CNT_W'(1);
               end
            end
            ACT_POPPUSH: begin
               stack[tos] <= ret_addr;
               if (count == '0)
                  count <= CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign ras.ras_valid  = count != '0;
   assign ras.ras_target = stack[tos];
   assign ras.ckpt_tos   = tos;
   assign ras.ckpt_count = count;
   assign ras.ckpt_top   = stack[tos];

endmodule

// File: tb/tb_return_address_stack.sv
// Randomized and directed checks of return_address_stack
// against a behavioural stack model.
module tb_return_address_stack;

   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   return_address_stack_if #(
      .XLEN(32), .PTR_W(PTR_W), .CNT_W(CNT_W)
   ) bus ();

   return_address_stack #(
      .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W), .XLEN(32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .ras  (bus.slave)
   );

   // Reference model: plain arrays and modular integer arithmetic.
   logic [31:0] mst [DEPTH];
   int          mtos;
   int          mcnt;

   function automatic logic [31:0] enc_jal(input int rd);
      logic [4:0] r;
      r = rd[4:0];
      return {20'h0, r, 7'h6F};
   endfunction

   function automatic logic [31:0] enc_jalr(input int rd, input int rs1);
      logic [4:0] a;
      logic [4:0] b;
      a = rd[4:0];
      b = rs1[4:0];
      return {12'h0, b, 3'b000, a, 7'h67};
   endfunction

   function automatic bit is_link(input int r);
      return r == 1 || r == 5;
   endfunction

   task automatic model_update(input logic [31:0] ins, input logic [31:0] p,
                               input bit fe, input bit re, input int rtos,
                               input int rcnt, input logic [31:0] rtop,
                               input bit rst);
      int rd;
      int rs1;
      int op;
      rd  = int'(ins[11:7]);
      rs1 = int'(ins[19:15]);
      op  = int'(ins[6:0]);
      if (rst) begin
         mtos = 0;
         mcnt = 0;
         for (int i = 0; i < DEPTH; i++) mst[i] = 32'h0;
      end else if (re) begin
         mtos = rtos;
         mcnt = rcnt;
         mst[rtos] = rtop;
      end else if (fe) begin
         bit do_push;
         bit do_pop;
         bit do_pp;
         do_push = 0;
         do_pop  = 0;
         do_pp   = 0;
         if (op == 'h6F) begin
            do_push = is_link(rd);
         end else if (op == 'h67) begin
            if (is_link(rd) && is_link(rs1) && rd != rs1) do_pp = 1;
            else if (is_link(rd)) do_push = 1;
            else if (is_link(rs1)) do_pop = 1;
         end
         if (do_push) begin
            mtos = (mtos + 1) % DEPTH;
            mst[mtos] = p + 32'd4;
            if (mcnt < DEPTH) mcnt = mcnt + 1;
         end else if (do_pop) begin
            if (mcnt > 0) begin
               mtos = (mtos + DEPTH - 1) % DEPTH;
               mcnt = mcnt - 1;
            end
         end else if (do_pp) begin
            mst[mtos] = p + 32'd4;
            if (mcnt == 0) mcnt = 1;
         end
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] p,
                       input bit fe, input bit re, input int rtos,
                       input int rcnt, input logic [31:0] rtop,
                       input bit rst);
      reset             = rst;
      bus.instruction   = ins;
      bus.pc            = p;
      bus.fetch_en      = fe;
      bus.recover_en    = re;
      bus.recover_tos   = rtos[PTR_W-1:0];
      bus.recover_count = rcnt[CNT_W-1:0];
      bus.recover_top   = rtop;
      @(posedge clk);
      model_update(ins, p, fe, re, rtos, rcnt, rtop, rst);
      #1;
      reset        = 1'b0;
      bus.fetch_en = 1'b0;
      bus.recover_en = 1'b0;
   endtask

   task automatic do_reset();
      step(32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 1);
   endtask

   task automatic fetch(input logic [31:0] ins, input logic [31:0] p);
      step(ins, p, 1, 0, 0, 0, 32'h0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (bus.ras_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%0b exp=0", bus.ras_valid);
      end
      total++;
      if ({bus.ras_target, bus.ckpt_top} !== 64'h0) begin
         bad++;
         $display("FAIL reset_target got=%h/%h exp=0",
                  bus.ras_target, bus.ckpt_top);
      end
      total++;
      if ({bus.ckpt_tos, bus.ckpt_count} !== 7'h0) begin
         bad++;
         $display("FAIL reset_ptr got=%0d/%0d exp=0/0",
                  bus.ckpt_tos, bus.ckpt_count);
      end
   endtask

   task automatic test_call_return();
      logic [31:0] exp;
      do_reset();
      fetch(enc_jal(1), 32'h100);
      total++;
      if (bus.ras_valid !== 1'b1 || bus.ras_target !== 32'h104 ||
          bus.ckpt_count !== 4'd1) begin
         bad++;
         $display("FAIL first_call got=%0b/%h/%0d exp=1/104/1",
                  bus.ras_valid, bus.ras_target, bus.ckpt_count);
      end
      fetch(enc_jal(1), 32'h200);
      fetch(enc_jalr(1, 0), 32'h300);
      for (int k = 0; k < 3; k++) begin
         exp = 32'h304 - 32'(k) * 32'h100;
         total++;
         if (bus.ras_target !== exp) begin
            bad++;
            $display("FAIL return_%0d got=%h exp=%h", k, bus.ras_target, exp);
         end
         fetch(enc_jalr(0, 1), 32'h800);
      end
      total++;
      if (bus.ras_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_after_returns got=%0b exp=0", bus.ras_valid);
      end
      fetch(enc_jalr(0, 5), 32'h800);
      total++;
      if (bus.ckpt_count !== 4'd0 || bus.ckpt_tos !== 3'd0) begin
         bad++;
         $display("FAIL underflow got=%0d/%0d exp=0/0",
                  bus.ckpt_count, bus.ckpt_tos);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++)
         fetch(enc_jal(5), 32'h1000 + 32'(i) * 32'h10);
      total++;
      if (bus.ckpt_count !== 4'd8) begin
         bad++;
         $display("FAIL overflow_count got=%0d exp=8", bus.ckpt_count);
      end
      for (int k = 0; k < DEPTH; k++) begin
         exp = 32'h1004 + 32'(DEPTH + 1 - k) * 32'h10;
         total++;
         if (bus.ras_valid !== 1'b1 || bus.ras_target !== exp) begin
            bad++;
            $display("FAIL overflow_pop_%0d got=%h exp=%h",
                     k, bus.ras_target, exp);
         end
         fetch(enc_jalr(0, 1), 32'h0);
      end
      total++;
      if (bus.ras_valid !== 1'b0 || bus.ckpt_count !== 4'd0) begin
         bad++;
         $display("FAIL overflow_drained got=%0b/%0d exp=0/0",
                  bus.ras_valid, bus.ckpt_count);
      end
   endtask

   task automatic test_poppush();
      do_reset();
      fetch(enc_jal(1), 32'h100);
      fetch(enc_jalr(1, 5), 32'h400);
      total++;
      if (bus.ras_target !== 32'h404 || bus.ckpt_count !== 4'd1 ||
          bus.ckpt_tos !== 3'd1) begin
         bad++;
         $display("FAIL poppush got=%h/%0d/%0d exp=404/1/1",
                  bus.ras_target, bus.ckpt_count, bus.ckpt_tos);
      end
      do_reset();
      fetch(enc_jalr(1, 5), 32'h400);
      total++;
      if (bus.ras_target !== 32'h404 || bus.ckpt_count !== 4'd1 ||
          bus.ckpt_tos !== 3'd0) begin
         bad++;
         $display("FAIL poppush_empty got=%h/%0d/%0d exp=404/1/0",
                  bus.ras_target, bus.ckpt_count, bus.ckpt_tos);
      end
      fetch(enc_jalr(5, 5), 32'hFFFF_FFFC);
      total++;
      if (bus.ras_target !== 32'h0 || bus.ckpt_count !== 4'd2) begin
         bad++;
         $display("FAIL push_wrap got=%h/%0d exp=0/2",
                  bus.ras_target, bus.ckpt_count);
      end
   endtask

   task automatic test_recovery();
      do_reset();
      fetch(enc_jal(1), 32'h100);
      total++;
      if (bus.ckpt_tos !== 3'd1 || bus.ckpt_count !== 4'd1 ||
          bus.ckpt_top !== 32'h104) begin
         bad++;
         $display("FAIL ckpt got=%0d/%0d/%h exp=1/1/104",
                  bus.ckpt_tos, bus.ckpt_count, bus.ckpt_top);
      end
      fetch(enc_jalr(0, 1), 32'h500);
      fetch(enc_jal(1), 32'h900);
      total++;
      if (bus.ras_target !== 32'h904) begin
         bad++;
         $display("FAIL wrong_path got=%h exp=904", bus.ras_target);
      end
      step(enc_jal(1), 32'hA00, 1, 1, 1, 1, 32'h104, 0);
      total++;
      if (bus.ckpt_tos !== 3'd1 || bus.ckpt_count !== 4'd1 ||
          bus.ras_target !== 32'h104) begin
         bad++;
         $display("FAIL recover got=%0d/%0d/%h exp=1/1/104",
                  bus.ckpt_tos, bus.ckpt_count, bus.ras_target);
      end
   endtask

   task automatic test_fetch_disable();
      do_reset();
      fetch(enc_jal(1), 32'h100);
      fetch(enc_jal(1), 32'h200);
      fetch(enc_jal(1), 32'h300);
      for (int k = 0; k < 3; k++)
         step(enc_jal(1), 32'h700, 0, 0, 0, 0, 32'h0, 0);
      total++;
      if (bus.ckpt_count !== 4'd3 || bus.ckpt_tos !== 3'd3 ||
          bus.ras_target !== 32'h304) begin
         bad++;
         $display("FAIL fetch_disable got=%0d/%0d/%h exp=3/3/304",
                  bus.ckpt_count, bus.ckpt_tos, bus.ras_target);
      end
      step(enc_jal(1), 32'h700, 1, 1, 5, 2, 32'h55, 1);
      total++;
      if (bus.ras_valid !== 1'b0 || bus.ckpt_count !== 4'd0) begin
         bad++;
         $display("FAIL mid_reset got=%0b/%0d exp=0/0",
                  bus.ras_valid, bus.ckpt_count);
      end
      fetch(enc_jalr(0, 1), 32'h0);
      total++;
      if (bus.ckpt_count !== 4'd0 || bus.ckpt_tos !== 3'd0) begin
         bad++;
         $display("FAIL pop_after_reset got=%0d/%0d exp=0/0",
                  bus.ckpt_count, bus.ckpt_tos);
      end
   endtask

   task automatic test_random();
      int          ckq_tos [$];
      int          ckq_cnt [$];
      logic [31:0] ckq_top [$];
      int          regs [4];
      int          n;
      regs = '{0, 1, 5, 7};
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [31:0] ins;
         logic [31:0] p;
         bit          fe;
         bit          re;
         bit          rst;
         int          sel;
         int          rd;
         int          rs1;
         int          rt;
         int          rc;
         logic [31:0] rp;
         rd  = regs[$urandom_range(3)];
         rs1 = regs[$urandom_range(3)];
         sel = $urandom_range(9);
         if (sel < 3) ins = enc_jal(rd);
         else if (sel < 8) ins = enc_jalr(rd, rs1);
         else ins = $urandom;
         p   = {$urandom_range(32'hFFFF), 2'b00} | ((sel == 9) ? 32'hFFFF_0000 : 32'h0);
         if ($urandom_range(20) == 0) p = 32'hFFFF_FFFC;
         fe  = $urandom_range(4) != 0;
         rst = $urandom_range(150) == 0;
         ckq_tos.push_back(mtos);
         ckq_cnt.push_back(mcnt);
         ckq_top.push_back(mst[mtos]);
         if (ckq_tos.size() > 4) begin
            void'(ckq_tos.pop_front());
            void'(ckq_cnt.pop_front());
            void'(ckq_top.pop_front());
         end
         re = $urandom_range(12) == 0;
         n  = $urandom_range(ckq_tos.size() - 1);
         rt = ckq_tos[n];
         rc = ckq_cnt[n];
         rp = ckq_top[n];
         step(ins, p, fe, re, rt, rc, rp, rst);
         total++;
         if (bus.ras_valid !== (mcnt != 0) ||
             bus.ras_target !== mst[mtos] ||
             bus.ckpt_top !== mst[mtos] ||
             bus.ckpt_tos !== 3'(mtos) ||
             bus.ckpt_count !== 4'(mcnt)) begin
            bad++;
            $display("FAIL random_%0d got=%0b/%h/%0d/%0d exp=%0b/%h/%0d/%0d",
                     c, bus.ras_valid, bus.ras_target, bus.ckpt_tos,
                     bus.ckpt_count, mcnt != 0, mst[mtos], mtos, mcnt);
         end
      end
   endtask

   initial begin
      reset             = 1'b1;
      bus.pc            = '0;
      bus.instruction   = '0;
      bus.fetch_en      = 1'b0;
      bus.recover_en    = 1'b0;
      bus.recover_tos   = '0;
      bus.recover_count = '0;
      bus.recover_top   = '0;
      mtos = 0;
      mcnt = 0;
      for (int i = 0; i < DEPTH; i++) mst[i] = 32'h0;
      test_reset();
      test_call_return();
      test_overflow();
      test_poppush();
      test_recovery();
      test_fetch_disable();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
